// File: rtl/burst_pulse_checker.sv
// rtl/burst_pulse_checker.sv - checks pulse count and pulse spacing inside each burst window
module burst_pulse_checker #(
    parameter int EXP_PULSES = 15,
    parameter int EXP_GAP    = 30,
    parameter int GAP_TOL    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       win_in,
    input  logic       pulse_in,
    input  logic       clr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       cnt_err,
    output logic       gap_err,
    output logic       stray_err,
    output logic [7:0] pulse_cnt,
    output logic [7:0] last_gap
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, REPORT} state_t;

    localparam logic [7:0] EXP_CNT   = 8'(EXP_PULSES);
    localparam logic [9:0] EXP_GAP10 = 10'(EXP_GAP);
    localparam logic [9:0] GAP_HI10  = 10'(EXP_GAP + GAP_TOL);
    localparam logic [9:0] GAP_TOL10 = 10'(GAP_TOL);

    state_t     state_q, state_d;
    logic       win_dly_q, pulse_dly_q;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       cnt_err_q, cnt_err_d;
    logic       gap_err_q, gap_err_d;
    logic       stray_err_q, stray_err_d;
    logic [7:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0] last_gap_q, last_gap_d;

    logic       win_rise, pulse_edge, arm_entry, gap_bad;
    logic [7:0] gap_inc, cnt_inc, spacing;
    logic [9:0] spacing10;

    assign win_rise   = win_in & ~win_dly_q;
    assign pulse_edge = pulse_in & ~pulse_dly_q;
    assign gap_inc    = (gap_cnt_q == 8'hFF) ? 8'hFF : gap_cnt_q + 8'd1;
    assign cnt_inc    = (pulse_cnt_q == 8'hFF) ? 8'hFF : pulse_cnt_q + 8'd1;
    assign spacing    = gap_inc;
    assign spacing10  = {2'b00, spacing};
    // |spacing - EXP_GAP| > GAP_TOL, rearranged to stay unsigned
    assign gap_bad    = (spacing10 > GAP_HI10) || ((spacing10 + GAP_TOL10) < EXP_GAP10);

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        cnt_err_d   = cnt_err_q;
        gap_err_d   = gap_err_q;
        stray_err_d = stray_err_q;
        pulse_cnt_d = pulse_cnt_q;
        last_gap_d  = last_gap_q;
        arm_entry   = 1'b0;

        case (state_q)
            IDLE, REPORT: begin
                if (pulse_edge) stray_err_d = 1'b1;
                if (win_rise) begin
                    state_d   = ARMED;
                    arm_entry = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            ARMED: begin
                gap_cnt_d = gap_inc;
                if (pulse_edge) begin
                    pulse_cnt_d = cnt_inc;
                    gap_cnt_d   = 8'd0;
                    state_d     = RUN;
                end
                if (!win_in) state_d = REPORT;
            end
            RUN: begin
                gap_cnt_d = gap_inc;
                if (pulse_edge) begin
                    last_gap_d  = spacing;
                    if (gap_bad) gap_err_d = 1'b1;
                    pulse_cnt_d = cnt_inc;
                    gap_cnt_d   = 8'd0;
                end
                if (!win_in) state_d = REPORT;
            end
            default: state_d = IDLE;
        endcase

        if (arm_entry) begin
            pulse_cnt_d = 8'd0;
            last_gap_d  = 8'd0;
            gap_err_d   = 1'b0;
            cnt_err_d   = 1'b0;
            pass_d      = 1'b0;
            gap_cnt_d   = 8'd0;
        end

        // Verdict uses the final counts, including a pulse on the closing cycle
        if (state_d == REPORT) begin
            done_d    = 1'b1;
            cnt_err_d = (pulse_cnt_d != EXP_CNT);
            pass_d    = ~cnt_err_d & ~gap_err_d;
        end

        if (clr) begin
            state_d     = IDLE;
            gap_cnt_d   = 8'd0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            cnt_err_d   = 1'b0;
            gap_err_d   = 1'b0;
            stray_err_d = 1'b0;
            pulse_cnt_d = 8'd0;
            last_gap_d  = 8'd0;
        end

        busy_d = (state_d == ARMED) || (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_dly_q   <= 1'b0;
            pulse_dly_q <= 1'b0;
            gap_cnt_q   <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cnt_err_q   <= 1'b0;
            gap_err_q   <= 1'b0;
            stray_err_q <= 1'b0;
            pulse_cnt_q <= 8'd0;
            last_gap_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            win_dly_q   <= win_in;
            pulse_dly_q <= pulse_in;
            gap_cnt_q   <= gap_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cnt_err_q   <= cnt_err_d;
            gap_err_q   <= gap_err_d;
            stray_err_q <= stray_err_d;
            pulse_cnt_q <= pulse_cnt_d;
            last_gap_q  <= last_gap_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign cnt_err   = cnt_err_q;
    assign gap_err   = gap_err_q;
    assign stray_err = stray_err_q;
    assign pulse_cnt = pulse_cnt_q;
    assign last_gap  = last_gap_q;

endmodule

// File: tb/tb_burst_pulse_checker.sv
// tb/tb_burst_pulse_checker.sv - directed self-checking bench for burst_pulse_checker
module tb_burst_pulse_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       win_in = 1'b0;
    logic       pulse_in = 1'b0;
    logic       clr = 1'b0;
    logic       busy, done, pass, cnt_err, gap_err, stray_err;
    logic [7:0] pulse_cnt, last_gap;
    logic       t_busy, t_done, t_pass, t_cnt_err, t_gap_err, t_stray_err;
    logic [7:0] t_pulse_cnt, t_last_gap;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    burst_pulse_checker u_dut (
        .clk(clk), .rst_n(rst_n), .win_in(win_in), .pulse_in(pulse_in), .clr(clr),
        .busy(busy), .done(done), .pass(pass), .cnt_err(cnt_err), .gap_err(gap_err),
        .stray_err(stray_err), .pulse_cnt(pulse_cnt), .last_gap(last_gap)
    );

    burst_pulse_checker #(.EXP_PULSES(15), .EXP_GAP(30), .GAP_TOL(1)) u_tol1 (
        .clk(clk), .rst_n(rst_n), .win_in(win_in), .pulse_in(pulse_in), .clr(clr),
        .busy(t_busy), .done(t_done), .pass(t_pass), .cnt_err(t_cnt_err), .gap_err(t_gap_err),
        .stray_err(t_stray_err), .pulse_cnt(t_pulse_cnt), .last_gap(t_last_gap)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic p);
        win_in   = w;
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {2'b00, busy, done, pass, cnt_err, gap_err, stray_err}, 8'd0);
        chk({tag, "_cnt"}, pulse_cnt, 8'd0);
        chk({tag, "_gap"}, last_gap, 8'd0);
    endtask

    task automatic burst(input int n, input int fault_i, input int fault_gap);
        int g;
        cyc(1'b1, 1'b0);
        chk("busy_after_rise", {7'd0, busy}, 8'd1);
        for (int i = 0; i < n; i++) begin
            g = (i == fault_i) ? fault_gap : 30;
            if (i > 0) repeat (g - 1) cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
        end
    endtask

    task automatic close_check(input string tag, input logic e_pass, input logic e_cnt_err,
                               input logic e_gap_err, input logic [7:0] e_cnt,
                               input logic [7:0] e_gap);
        cyc(1'b0, 1'b0);
        chk({tag, "_done"}, {7'd0, done}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_pass"}, {7'd0, pass}, {7'd0, e_pass});
        chk({tag, "_cnt_err"}, {7'd0, cnt_err}, {7'd0, e_cnt_err});
        chk({tag, "_gap_err"}, {7'd0, gap_err}, {7'd0, e_gap_err});
        chk({tag, "_pulse_cnt"}, pulse_cnt, e_cnt);
        chk({tag, "_last_gap"}, last_gap, e_gap);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk("idle_busy", {7'd0, busy}, 8'd0);

        // nominal burst, then results hold in IDLE
        burst(15, -1, 0);
        close_check("nom", 1'b1, 1'b0, 1'b0, 8'd15, 8'd30);
        cyc(1'b0, 1'b0);
        chk("nom_after_busy", {7'd0, busy}, 8'd0);
        chk("nom_after_done", {7'd0, done}, 8'd0);
        chk("nom_hold_pass", {7'd0, pass}, 8'd1);
        chk("nom_hold_cnt", pulse_cnt, 8'd15);

        burst(14, -1, 0);
        close_check("short", 1'b0, 1'b1, 1'b0, 8'd14, 8'd30);
        cyc(1'b0, 1'b0);

        // 7th pulse (index 6) late by one cycle
        burst(15, 6, 31);
        close_check("gapfault", 1'b0, 1'b0, 1'b1, 8'd15, 8'd30);
        chk("gapfault_tol1_pass", {7'd0, t_pass}, 8'd1);
        chk("gapfault_tol1_gap_err", {7'd0, t_gap_err}, 8'd0);
        cyc(1'b0, 1'b0);

        chk("stray_before", {7'd0, stray_err}, 8'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("stray_set", {7'd0, stray_err}, 8'd1);
        burst(15, -1, 0);
        close_check("stray_nom", 1'b1, 1'b0, 1'b0, 8'd15, 8'd30);
        chk("stray_sticky", {7'd0, stray_err}, 8'd1);
        cyc(1'b0, 1'b0);
        clr = 1'b1;
        cyc(1'b0, 1'b0);
        clr = 1'b0;
        chk_all_zero("clr");

        // reset in the middle of a window, win stays high through release
        burst(5, -1, 0);
        d0 = done_cnt;
        pulse_in = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_no_done", 8'(done_cnt), 8'(d0));
        burst(15, -1, 0);
        close_check("post_rst", 1'b1, 1'b0, 1'b0, 8'd15, 8'd30);
        cyc(1'b0, 1'b0);

        // back-to-back windows; second window uses one 3-cycle-wide pulse
        burst(15, -1, 0);
        close_check("b2b_first", 1'b1, 1'b0, 1'b0, 8'd15, 8'd30);
        cyc(1'b1, 1'b0);
        chk("b2b_rearm_busy", {7'd0, busy}, 8'd1);
        chk("b2b_rearm_done", {7'd0, done}, 8'd0);
        chk("b2b_rearm_cnt", pulse_cnt, 8'd0);
        chk("b2b_rearm_pass", {7'd0, pass}, 8'd0);
        chk("b2b_rearm_gap", last_gap, 8'd0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("wide_pulse_once", pulse_cnt, 8'd1);
        close_check("b2b_second", 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        cyc(1'b0, 1'b0);

        chk("done_total", 8'(done_cnt), 8'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
